// File: rtl/truthtable_pkg.sv
// Shared definitions for the truth-table function block: default table,
// index type and the table lookup helper used by the LUT.
package truthtable_pkg;

  // Default table realises f = x3 ? x1 : x2 (ones at idx 2, 3, 5, 7).
  localparam logic [7:0] TT_DEFAULT = 8'hAC;

  // Table index, ordered {x3, x2, x1}.
  typedef logic [2:0] idx_t;

  // Select one table bit; an unknown index yields X so that input X
  // propagates to the result instead of being masked.
  function automatic logic tt_lookup(input logic [7:0] tbl, input idx_t idx);
    return tbl[idx];
  endfunction

endpackage

// File: rtl/truthtable_lut.sv
// Combinational 3-input lookup: returns the table bit selected by idx.
module truthtable_lut
  import truthtable_pkg::*;
(
  input  logic [7:0] tbl,
  input  idx_t       idx,
  output logic       f
);

  // Pure lookup, no state.
  assign f = tt_lookup(tbl, idx);

endmodule

// File: rtl/truthtable_top.sv
// Three-input Boolean function block. f is the combinational result of a
// table lookup on {x3,x2,x1}; f_q is its registered copy and ones_cnt a
// saturating count of clocks on which f was 1.
// Optional feature macro: TRUTHTABLE_PROG_EN adds a writable 8-bit table
// register (ports tt_we, tt_wdata, tt). Without it the table is TT_RESET.
module truthtable_top
  import truthtable_pkg::*;
#(
  parameter int         CNT_W    = 8,
  parameter logic [7:0] TT_RESET = TT_DEFAULT
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x3,
  input  logic             x2,
  input  logic             x1,
  output logic             f,
  output logic             f_q,
  output logic [CNT_W-1:0] ones_cnt
`ifdef TRUTHTABLE_PROG_EN
  ,
  input  logic             tt_we,
  input  logic [7:0]       tt_wdata,
  output logic [7:0]       tt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]       tbl_s;
  idx_t             idx_s;
  logic             f_s;
  logic             f_q_r;
  logic [CNT_W-1:0] ones_cnt_r;

  assign idx_s = {x3, x2, x1};

`ifdef TRUTHTABLE_PROG_EN
  logic [7:0] tt_r;

  // Table register: reset to TT_RESET, writes are ignored while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_r <= TT_RESET;
    end else if (tt_we) begin
      tt_r <= tt_wdata;
    end else begin
      tt_r <= tt_r;
    end
  end

  assign tbl_s = tt_r;
  assign tt    = tt_r;
`else
  assign tbl_s = TT_RESET;
`endif

  truthtable_lut u_lut (
    .tbl (tbl_s),
    .idx (idx_s),
    .f   (f_s)
  );

  assign f = f_s;

  // Registered copy of f for synchronous consumers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q_r <= 1'b0;
    end else begin
      f_q_r <= f_s;
    end
  end

  // Ones counter; holds at all-ones instead of wrapping. The f sampled here
  // is the pre-edge value, so a same-edge table write does not affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt_r <= {CNT_W{1'b0}};
    end else if ((f_s == 1'b1) && (ones_cnt_r != CNT_MAX)) begin
      ones_cnt_r <= ones_cnt_r + CNT_ONE;
    end else begin
      ones_cnt_r <= ones_cnt_r;
    end
  end

  assign f_q      = f_q_r;
  assign ones_cnt = ones_cnt_r;

endmodule

// File: tb/tb_truthtable_top.sv
// Testbench for truthtable_top: directed and random stimulus against a
// behavioural model (table as integer, counters as saturating integers).
// A second instance with CNT_W=4 exercises counter saturation.
module tb_truthtable_top;

  logic       clk;
  logic       rst_n;
  logic       x3, x2, x1;
  logic       f, f_q, f4, f_q4;
  logic [7:0] ones_cnt;
  logic [3:0] ones_cnt4;
`ifdef TRUTHTABLE_PROG_EN
  logic       tt_we;
  logic [7:0] tt_wdata;
  logic [7:0] tt, tt4;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int   tbl_m     = 172;   // 0xAC
  int   exp_cnt   = 0;
  int   exp_cnt4  = 0;
  logic exp_fq    = 1'b0;

  truthtable_top #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .x3(x3), .x2(x2), .x1(x1),
    .f(f), .f_q(f_q), .ones_cnt(ones_cnt)
`ifdef TRUTHTABLE_PROG_EN
    , .tt_we(tt_we), .tt_wdata(tt_wdata), .tt(tt)
`endif
  );

  truthtable_top #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .x3(x3), .x2(x2), .x1(x1),
    .f(f4), .f_q(f_q4), .ones_cnt(ones_cnt4)
`ifdef TRUTHTABLE_PROG_EN
    , .tt_we(tt_we), .tt_wdata(tt_wdata), .tt(tt4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_f(input int n);
    return (((tbl_m >> n) & 1) != 0);
  endfunction

  function automatic int cur_idx();
    return (x3 ? 4 : 0) + (x2 ? 2 : 0) + (x1 ? 1 : 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".f_q"}, 32'(f_q), 32'(exp_fq));
    chk({tag, ".f_q4"}, 32'(f_q4), 32'(exp_fq));
    chk({tag, ".cnt"}, 32'(ones_cnt), 32'(exp_cnt));
    chk({tag, ".cnt4"}, 32'(ones_cnt4), 32'(exp_cnt4));
  endtask

  // Drive inputs (called just after negedge), check f, clock once, check regs.
  task automatic step(input logic a3, input logic a2, input logic a1, input string tag);
    logic ef;
    x3 = a3; x2 = a2; x1 = a1;
    #1;
    ef = model_f(cur_idx());
    chk({tag, ".f_lo"}, 32'(f), 32'(ef));
    chk({tag, ".f4_lo"}, 32'(f4), 32'(ef));
    @(posedge clk);
    if (rst_n) begin
      exp_fq = ef;
      if (ef) begin
        if (exp_cnt < 255) exp_cnt++;
        if (exp_cnt4 < 15) exp_cnt4++;
      end
`ifdef TRUTHTABLE_PROG_EN
      if (tt_we) tbl_m = int'(tt_wdata);
`endif
    end
    #1;
    chk({tag, ".f_hi"}, 32'(f), 32'(model_f(cur_idx())));
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_cnt = 0; exp_cnt4 = 0; exp_fq = 1'b0;
    tbl_m = 172;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    x3 = 1'b0; x2 = 1'b0; x1 = 1'b0;
`ifdef TRUTHTABLE_PROG_EN
    tt_we = 1'b0; tt_wdata = 8'h00;
`endif
    @(negedge clk);
    #1;
    check_regs("reset");
    chk("reset.f", 32'(f), 32'(1'b0));
`ifdef TRUTHTABLE_PROG_EN
    chk("reset.tt", 32'(tt), 32'hAC);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Sweep the default table: expected 0,0,1,1,0,1,0,1
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(v[2], v[1], v[0], "sweep");
      chk("sweep.rule", 32'(f), 32'(((i == 2) || (i == 3) || (i == 5) || (i == 7)) ? 1'b1 : 1'b0));
    end

    // Hold idx=3 for 10 clocks after reset release, then 10 more
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, "hold");
    chk("hold.cnt10", 32'(ones_cnt), 32'd10);
    chk("hold.fq", 32'(f_q), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, "sat");
    chk("sat.cnt4_15", 32'(ones_cnt4), 32'd15);
    chk("sat.cnt20", 32'(ones_cnt), 32'd20);

    // Asynchronous reset in the middle of the high phase with count 5
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, "pre");
    chk("pre.cnt5", 32'(ones_cnt), 32'd5);
    @(posedge clk);
    if (1'b1 == model_f(cur_idx())) begin
      exp_cnt++; exp_cnt4++;
    end
    #2;
    rst_n = 1'b0;
    exp_cnt = 0; exp_cnt4 = 0; exp_fq = 1'b0;
    #1;
    check_regs("async");
    x3 = 1'b0; x2 = 1'b1; x1 = 1'b0;
    #1;
    chk("async.f_track1", 32'(f), 32'd1);
    x3 = 1'b1; x2 = 1'b1; x1 = 1'b0;
    #1;
    chk("async.f_track0", 32'(f), 32'd0);
    @(negedge clk);
    step(1'b1, 1'b1, 1'b1, "inrst");
    rst_n = 1'b1;

    // Random vectors against the select rule and the counter model
    for (int i = 0; i < 40; i++) begin
      logic r3, r2, r1;
      r3 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      step(r3, r2, r1, "rand");
      chk("rand.mux", 32'(f), 32'(r3 ? r1 : r2));
    end

    // X on an input must reach f
    x3 = 1'bx; x2 = 1'b0; x1 = 1'b1;
    #1;
    chk("xprop", 32'(f), 32'(1'bx));
    x3 = 1'b0;
    @(negedge clk);

`ifdef TRUTHTABLE_PROG_EN
    // Write 0x01 on an edge where f=1 under the old table
    do_reset();
    tt_we = 1'b1; tt_wdata = 8'h01;
    step(1'b0, 1'b1, 1'b1, "ttwr");
    tt_we = 1'b0;
    chk("ttwr.tt", 32'(tt), 32'h01);
    chk("ttwr.cnt_old", 32'(ones_cnt), 32'd1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(v[2], v[1], v[0], "tt01");
      chk("tt01.rule", 32'(f), 32'((i == 0) ? 1'b1 : 1'b0));
    end
    // Writes during reset are ignored; reset restores 0xAC
    rst_n = 1'b0;
    tbl_m = 172; exp_cnt = 0; exp_cnt4 = 0; exp_fq = 1'b0;
    #1;
    chk("ttrst.tt", 32'(tt), 32'hAC);
    tt_we = 1'b1; tt_wdata = 8'h55;
    @(posedge clk);
    #1;
    chk("ttrst.ign", 32'(tt), 32'hAC);
    @(negedge clk);
    tt_we = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, "ttpost");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
